// File: rtl/spi_word_receiver.sv
// spi_word_receiver: SPI mode-0 target-side deserialiser.
// Oversamples cs/sclk/sdo in the clk domain, assembles MSB-first words of
// WIDTH bits and hands them out on a valid/ready port. It also flags a word
// that completes before the previous one was taken (overrun) and a frame
// that ends on a partial word (frame_err).
//
//   state  | meaning
//   IDLE   | no frame; waiting for synchronised cs to fall
//   ACTIVE | frame open; shifting one bit per detected sclk rise
module spi_word_receiver #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             sclk,
  input  logic             sdo,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;

  logic cs_s1, cs_s2, cs_s3;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic sdo_s1, sdo_s2;

  logic             sclk_rise;
  logic             cs_fall;
  logic             cs_rise;
  logic             word_done;
  logic [WIDTH-1:0] next_word;

  // Two-flop synchronisers on all lines; sdo_s2 lines up with sclk_s2 so the
  // data bit is taken with the same delay as the clock edge that qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      sdo_s1  <= 1'b0;
      sdo_s2  <= 1'b0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      sdo_s1  <= sdo;
      sdo_s2  <= sdo_s1;
    end
  end

  // Edge detection on the synchronised lines and the word being assembled.
  always_comb begin
    sclk_rise = sclk_s2 & ~sclk_s3;
    cs_fall   = ~cs_s2 & cs_s3;
    cs_rise   = cs_s2 & ~cs_s3;
    next_word = {shift_reg[WIDTH-2:0], sdo_s2};
    word_done = (state == ACTIVE) && sclk_rise && (bit_cnt == LAST);
  end

  // Frame FSM with registered outputs; a bit arriving with cs rise is taken
  // first, so a completing bit suppresses frame_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data       <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          busy    <= 1'b0;
          bit_cnt <= '0;
          if (cs_fall) begin
            state <= ACTIVE;
            busy  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            shift_reg <= next_word;
            if (bit_cnt == LAST) begin
              bit_cnt    <= '0;
              data       <= next_word;
              valid      <= 1'b1;
              word_count <= word_count + CNT_W'(1);
              overrun    <= valid && !ready;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          if (cs_rise) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            if (!word_done && (bit_cnt != '0 || sclk_rise)) begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_receiver.sv
// tb_spi_word_receiver: scoreboard bench for spi_word_receiver (WIDTH=16).
// Stimulus pushes the expected word/overrun/count when it issues the final
// bit; an independent monitor pops and compares whenever word_count moves.
module tb_spi_word_receiver;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        sclk;
  logic        sdo;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        overrun;
  logic        frame_err;
  logic        busy;
  logic [7:0]  word_count;

  spi_word_receiver #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .sdo(sdo),
    .data(data), .valid(valid), .ready(ready), .overrun(overrun),
    .frame_err(frame_err), .busy(busy), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        ovr;
    int          cnt;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  bit pending = 0;
  int exp_ovr = 0;
  int exp_fe = 0;
  int fe_cycles = 0;
  int ovr_cycles = 0;
  int vrise = 0;
  logic [7:0]  last_cnt = '0;
  logic        prev_valid = 1'b0;
  logic [15:0] last_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a word is pending until the consumer takes it; a new
  // word arriving while one is pending and ready is low is an overrun.
  task automatic push_word(input logic [15:0] w);
    exp_t e;
    e.d = w;
    e.ovr = pending && !ready;
    model_count = (model_count + 1) % 256;
    e.cnt = model_count;
    sb.push_back(e);
    if (e.ovr) exp_ovr++;
    pending = !ready;
    last_word = w;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input bit chk_lat);
    int lat;
    for (int i = 0; i < n; i++) begin
      sdo = w[15-i];
      tick(4);
      sclk = 1'b1;
      if (i == 15) push_word(w);
      if (chk_lat && i == 15) begin
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
          tick(1);
          if (lat == 0 && valid) lat = k;
        end
        check("latency_le4", (lat >= 1 && lat <= 4) ? 32'd1 : 32'd0, 32'd1);
      end else begin
        tick(4);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start;
    cs = 1'b0;
    tick(4);
  endtask

  task automatic frame_end;
    tick(4);
    cs = 1'b1;
    tick(8);
  endtask

  // Monitor: every change of word_count is one delivered word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_cnt   = '0;
      prev_valid = 1'b0;
    end else begin
      if (frame_err) fe_cycles++;
      if (overrun) ovr_cycles++;
      if (valid && !prev_valid) vrise++;
      if (word_count != last_cnt) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", data);
        end else begin
          e = sb.pop_front();
          check("word_data", data, e.d);
          check("word_overrun", overrun, e.ovr);
          check("word_count", word_count, e.cnt);
        end
        last_cnt = word_count;
      end
      prev_valid = valid;
    end
  end

  initial begin
    int vr0;
    int nw;
    rst_n = 1'b0;
    cs    = 1'b1;
    sclk  = 1'b0;
    sdo   = 1'b0;
    ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_word_count", word_count, 0);

    // single word, latency
    frame_start();
    check("busy_in_frame", busy, 1);
    send_bits(16'hA5C3, 16, 1'b1);
    frame_end();
    check("busy_after_frame", busy, 0);
    check("a5c3_data", data, 16'hA5C3);
    check("a5c3_count", word_count, model_count);
    check("a5c3_drain", sb.size(), 0);

    // overrun with ready low
    ready = 1'b0;
    frame_start();
    send_bits(16'h1234, 16, 1'b0);
    send_bits(16'hFFFF, 16, 1'b0);
    frame_end();
    check("ovr_cycles", ovr_cycles, exp_ovr);
    check("ovr_data", data, 16'hFFFF);
    check("ovr_valid", valid, 1);
    check("ovr_count", word_count, model_count);
    tick(3);
    check("ovr_data_stable", data, 16'hFFFF);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    pending = 0;
    tick(1);
    check("accept_clears_valid", valid, 0);
    ready = 1'b1;

    // partial frame then a good one
    frame_start();
    send_bits(16'h5A5A, 9, 1'b0);
    exp_fe++;
    frame_end();
    check("fe_cycles", fe_cycles, exp_fe);
    check("fe_valid", valid, 0);
    check("fe_count", word_count, model_count);
    frame_start();
    send_bits(16'h0001, 16, 1'b0);
    frame_end();
    check("after_fe_data", data, 16'h0001);
    check("after_fe_no_err", fe_cycles, exp_fe);

    // random multi-word frames
    for (int f = 0; f < 4; f++) begin
      nw = $urandom_range(1, 3);
      frame_start();
      for (int j = 0; j < nw; j++) send_bits(16'($urandom), 16, 1'b0);
      frame_end();
      check("rand_last_data", data, last_word);
      check("rand_count", word_count, model_count);
    end

    // reset mid-word
    frame_start();
    send_bits(16'h5555, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_data", data, 0);
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", word_count, 0);
    check("midrst_fe", frame_err, 0);
    model_count = 0;
    pending = 0;
    cs = 1'b1;
    sclk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    frame_start();
    send_bits(16'hBEEF, 16, 1'b0);
    frame_end();
    check("beef_data", data, 16'hBEEF);
    check("beef_count", word_count, 1);
    check("beef_no_fe", fe_cycles, exp_fe);

    // 256 words: counter wraps through zero
    vr0 = vrise;
    frame_start();
    for (int j = 0; j < 256; j++) send_bits(16'($urandom), 16, 1'b0);
    frame_end();
    check("wrap_valid_pulses", vrise - vr0, 256);
    check("wrap_count", word_count, model_count);
    check("wrap_overrun", ovr_cycles, exp_ovr);

    check("final_drain", sb.size(), 0);
    check("final_fe", fe_cycles, exp_fe);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
